// File: rtl/ides8_align_pkg.sv
// rtl/ides8_align_pkg.sv - shared state type and constants for the IDES8 word aligner
package ides8_align_pkg;

    localparam logic [7:0] DEFAULT_SYNC_PATTERN = 8'hB5;
    localparam int         CNT_W                = 4;
    localparam int         SLIP_W               = 8;
    localparam int         STAT_W               = 8;

    typedef enum logic [2:0] {
        ST_SEARCH,
        ST_VERIFY,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCKED
    } align_state_t;

endpackage

// File: rtl/ides8_word_aligner.sv
// rtl/ides8_word_aligner.sv - IDES8 bitslip word aligner; IDES8_ALIGN_STATS_EN adds slip_cnt_o
module ides8_word_aligner
    import ides8_align_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN = DEFAULT_SYNC_PATTERN,
    parameter int         LOCK_COUNT   = 4,
    parameter int         CALIB_SETTLE = 3,
    parameter int         MAX_SLIPS    = 8
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic [7:0] q_i,
    input  logic       realign_i,
    output logic       calib_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       locked_o,
    output logic       error_o
`ifdef IDES8_ALIGN_STATS_EN
    ,
    output logic [7:0] slip_cnt_o
`endif
);

    localparam logic [CNT_W-1:0]  LOCK_L      = CNT_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(CALIB_SETTLE - 1);
    localparam logic [SLIP_W-1:0] MAX_L       = SLIP_W'(MAX_SLIPS);

    align_state_t      state, state_nxt;
    logic [CNT_W-1:0]  match_cnt, match_nxt;
    logic [CNT_W-1:0]  settle_cnt, settle_nxt;
    logic [SLIP_W-1:0] slip_try, slip_nxt;
    logic              err_set;
    logic              match;

    assign match = (q_i == SYNC_PATTERN);

    always_comb begin
        state_nxt  = state;
        match_nxt  = match_cnt;
        settle_nxt = settle_cnt;
        slip_nxt   = slip_try;
        err_set    = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (match) begin
                    match_nxt = CNT_W'(1);
                    if (LOCK_L == CNT_W'(1)) begin
                        state_nxt = ST_LOCKED;
                        slip_nxt  = '0;
                    end else begin
                        state_nxt = ST_VERIFY;
                    end
                end else begin
                    match_nxt = '0;
                    state_nxt = ST_SLIP;
                end
            end
            ST_VERIFY: begin
                if (match) begin
                    match_nxt = match_cnt + CNT_W'(1);
                    if (match_cnt + CNT_W'(1) == LOCK_L) begin
                        state_nxt = ST_LOCKED;
                        slip_nxt  = '0;
                    end
                end else begin
                    match_nxt = '0;
                    state_nxt = ST_SLIP;
                end
            end
            ST_SLIP: begin
                settle_nxt = '0;
                state_nxt  = ST_SETTLE;
                // Slip budget wraps so the search keeps going after flagging the error.
                if (slip_try + SLIP_W'(1) == MAX_L) begin
                    slip_nxt = '0;
                    err_set  = 1'b1;
                end else begin
                    slip_nxt = slip_try + SLIP_W'(1);
                end
            end
            ST_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_nxt = '0;
                    state_nxt  = ST_SEARCH;
                end else begin
                    settle_nxt = settle_cnt + CNT_W'(1);
                end
            end
            ST_LOCKED: state_nxt = ST_LOCKED;
            default:   state_nxt = ST_SEARCH;
        endcase
        if (realign_i) begin
            state_nxt  = ST_SEARCH;
            match_nxt  = '0;
            settle_nxt = '0;
            slip_nxt   = '0;
            err_set    = 1'b0;
        end
    end

    // Outputs are decoded from the next state so each one comes straight off a flop.
    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state      <= ST_SEARCH;
            match_cnt  <= '0;
            settle_cnt <= '0;
            slip_try   <= '0;
            calib_o    <= 1'b0;
            data_o     <= '0;
            valid_o    <= 1'b0;
            locked_o   <= 1'b0;
            error_o    <= 1'b0;
        end else begin
            state      <= state_nxt;
            match_cnt  <= match_nxt;
            settle_cnt <= settle_nxt;
            slip_try   <= slip_nxt;
            calib_o    <= (state_nxt == ST_SLIP);
            valid_o    <= (state_nxt == ST_LOCKED);
            locked_o   <= (state_nxt == ST_LOCKED);
            if (state_nxt == ST_LOCKED) begin
                data_o <= q_i;
            end
            if (realign_i) begin
                error_o <= 1'b0;
            end else if (err_set) begin
                error_o <= 1'b1;
            end
        end
    end

`ifdef IDES8_ALIGN_STATS_EN
    logic [STAT_W-1:0] slip_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!nrst_i || realign_i) begin
            slip_cnt_q <= '0;
        end else if (state_nxt == ST_SLIP && slip_cnt_q != '1) begin
            slip_cnt_q <= slip_cnt_q + STAT_W'(1);
        end
    end

    assign slip_cnt_o = slip_cnt_q;
`endif

endmodule

// File: tb/tb_ides8_word_aligner.sv
// tb/tb_ides8_word_aligner.sv - scoreboard bench for ides8_word_aligner with a rotating IDES8 source model
module tb_ides8_word_aligner;

    localparam logic [7:0] PAT      = 8'hB5;
    localparam int         LOCK_N   = 4;
    localparam int         SETTLE_N = 3;
    localparam int         MAX_N    = 8;
    localparam int         ATTEMPT  = 2 + SETTLE_N;

    typedef enum int {M_MATCH, M_NOMATCH, M_ROT, M_RAND} mode_t;

    logic       clk = 1'b0;
    logic       nrst;
    logic       realign;
    logic [7:0] q;
    logic       calib;
    logic [7:0] data;
    logic       valid;
    logic       locked;
    logic       error;
`ifdef IDES8_ALIGN_STATS_EN
    logic [7:0] slip_cnt;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    mode_t      mode = M_NOMATCH;
    int         init_rot = 0;
    int         pulse_base = 0;
    int         ncyc = 0;
    int         n_valid = 0;
    int         rises[$];
    logic [7:0] script[$];
    logic [7:0] exp_q[$];

    ides8_word_aligner #(
        .SYNC_PATTERN(PAT),
        .LOCK_COUNT  (LOCK_N),
        .CALIB_SETTLE(SETTLE_N),
        .MAX_SLIPS   (MAX_N)
    ) dut (
        .clk_i    (clk),
        .nrst_i   (nrst),
        .q_i      (q),
        .realign_i(realign),
        .calib_o  (calib),
        .data_o   (data),
        .valid_o  (valid),
        .locked_o (locked),
        .error_o  (error)
`ifdef IDES8_ALIGN_STATS_EN
        ,
        .slip_cnt_o(slip_cnt)
`endif
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic int pulses();
        return rises.size() - pulse_base;
    endfunction

    // IDES8 source: bit alignment advances by one position on every calib pulse it sees.
    initial begin : ides8_model
        int         run;
        logic [7:0] w;
        run = 0;
        q   = 8'h00;
        forever begin
            @(negedge clk);
            ncyc++;
            if (calib === 1'b1) begin
                if (run == 0) rises.push_back(ncyc);
                run++;
            end else if (run != 0) begin
                check("calib_width", run, 1);
                run = 0;
            end
            if (script.size() > 0) begin
                w = script.pop_front();
            end else begin
                case (mode)
                    M_MATCH: w = PAT;
                    M_ROT:   w = rotl8(PAT, ((init_rot - pulses()) % 8 + 8) % 8);
                    M_RAND:  w = 8'($urandom);
                    default: begin
                        w = 8'($urandom);
                        if (w == PAT) w = ~PAT;
                    end
                endcase
            end
            q = w;
            exp_q.push_back(w);
        end
    end

    initial begin : sb_monitor
        logic [7:0] w;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                w = exp_q[$];
                exp_q.delete();
                if (valid === 1'b1) begin
                    n_valid++;
                    check("data_o", data, w);
                end
            end else if (valid === 1'b1) begin
                check("data_o_unexpected", 1, 0);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_realign();
        realign = 1'b1;
        tick();
        realign = 1'b0;
    endtask

    task automatic wait_lock(output int cnt, input int limit);
        cnt = 0;
        while (locked !== 1'b1 && cnt < limit) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_pulses(input int target, input int limit);
        int cnt;
        cnt = 0;
        while (pulses() < target && cnt < limit) begin
            tick();
            cnt++;
        end
    endtask

    initial begin : stim
        int cnt;
        int c0;
        int vb;
        nrst    = 1'b0;
        realign = 1'b0;
        tick();
        tick();
        check("rst_calib", calib, 0);
        check("rst_valid", valid, 0);
        check("rst_locked", locked, 0);
        check("rst_error", error, 0);
        check("rst_data", data, 0);

        // Aligned source: lock after LOCK_N matches, no slips, data streams with 1-cycle latency.
        for (int i = 0; i < LOCK_N; i++) script.push_back(PAT);
        mode       = M_RAND;
        pulse_base = rises.size();
        nrst       = 1'b1;
        do_realign();
        wait_lock(cnt, 60);
        check("A_lock_cycles", cnt, LOCK_N);
        check("A_pulses", pulses(), 0);
        check("A_valid", valid, 1);
        check("A_error", error, 0);
        vb = n_valid;
        repeat (16) tick();
        check("A_valid_stream", n_valid - vb, 16);

        // Source rotated by 3: three slips, each separated by the settle window.
        mode       = M_ROT;
        init_rot   = 3;
        pulse_base = rises.size();
        do_realign();
        wait_lock(cnt, 200);
        check("B_lock_cycles", cnt, 3 * ATTEMPT + LOCK_N);
        check("B_pulses", pulses(), 3);
        for (int i = 1; i < 3; i++)
            check("B_pulse_gap", rises[pulse_base + i] - rises[pulse_base + i - 1], ATTEMPT);
        check("B_error", error, 0);
`ifdef IDES8_ALIGN_STATS_EN
        check("B_slip_cnt", slip_cnt, 3);
`endif

        // Never matches: error after MAX_N pulses, pulses keep coming, later lock keeps error.
        mode       = M_NOMATCH;
        pulse_base = rises.size();
        do_realign();
        wait_pulses(MAX_N, 300);
        check("C_pulses_reached", pulses(), MAX_N);
        check("C_error_before", error, 0);
        tick();
        check("C_error_set", error, 1);
        wait_pulses(MAX_N + 2, 60);
        check("C_pulses_continue", pulses(), MAX_N + 2);
        mode = M_MATCH;
        wait_lock(cnt, 60);
        check("C_locked", locked, 1);
        check("C_error_held", error, 1);

        // Two matches then a miss in VERIFY; words during settle are ignored.
        script.push_back(PAT);
        script.push_back(PAT);
        script.push_back(8'h3C);
        mode       = M_MATCH;
        pulse_base = rises.size();
        c0         = ncyc;
        do_realign();
        wait_lock(cnt, 60);
        check("D_pulses", pulses(), 1);
        check("D_pulse_time", rises[pulse_base] - c0, 4);
        check("D_lock_cycles", cnt, 3 + (1 + SETTLE_N) + LOCK_N);

        // Realign while locked clears status outputs on the next edge.
        mode       = M_NOMATCH;
        pulse_base = rises.size();
        do_realign();
        check("E_locked", locked, 0);
        check("E_valid", valid, 0);
        check("E_error", error, 0);

        // Realign inside SLIP: pulse finishes, search resumes immediately.
        wait_pulses(1, 60);
        check("E_in_slip", calib, 1);
        pulse_base = rises.size();
        c0         = ncyc;
        do_realign();
        check("E_calib_done", calib, 0);
        check("E_slip_locked", locked, 0);
        check("E_slip_error", error, 0);
        wait_pulses(1, 60);
        check("E_next_pulse", rises[rises.size() - 1] - c0, 2);

        // Reset during SETTLE aborts the slip sequence.
        pulse_base = rises.size();
        wait_pulses(1, 60);
        tick();
        nrst = 1'b0;
        mode = M_MATCH;
        tick();
        check("F_calib", calib, 0);
        check("F_valid", valid, 0);
        check("F_locked", locked, 0);
        check("F_error", error, 0);
        check("F_data", data, 0);
`ifdef IDES8_ALIGN_STATS_EN
        check("F_slip_cnt", slip_cnt, 0);
`endif
        pulse_base = rises.size();
        nrst       = 1'b1;
        wait_lock(cnt, 60);
        check("F_lock_cycles", cnt, LOCK_N);
        check("F_pulses", pulses(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ides8_word_aligner.md
IDES8_WORD_ALIGNER -- requirements
Module: ides8_word_aligner

Interface
REQ-001 SHALL have parameter SYNC_PATTERN, default 8'hB5, meaning the training word sought in q_i.
REQ-002 SHALL have parameter LOCK_COUNT, default 4, meaning the consecutive matches required for lock (legal range 1..15).
REQ-003 SHALL have parameter CALIB_SETTLE, default 3, meaning the idle cycles after each calib pulse before re-checking (legal range 1..15).
REQ-004 SHALL have parameter MAX_SLIPS, default 8, meaning the slips without lock before error_o is raised (legal range 1..255).
REQ-005 clk_i  in  1  sole clock; this is the IDES8 PCLK domain.
REQ-006 nrst_i  in  1  reset; synchronous and active-low.
REQ-007 q_i  in  8  parallel word from IDES8 Q7..Q0.
REQ-008 realign_i  in  1  single-cycle request to restart alignment.
REQ-009 calib_o  out  1  bitslip pulse to IDES8 CALIB.
REQ-010 data_o  out  8  aligned word.
REQ-011 valid_o  out  1  data_o qualifier.
REQ-012 locked_o  out  1  alignment achieved.
REQ-013 error_o  out  1  sticky flag: MAX_SLIPS exceeded.

Function
REQ-014 FSM states SHALL be SEARCH, VERIFY, SLIP, SETTLE and LOCKED; match SHALL mean (q_i == SYNC_PATTERN), evaluated combinationally on the current q_i.
REQ-015 SEARCH: on match, go to VERIFY with match_cnt=1, or to LOCKED if LOCK_COUNT==1; on no match, go to SLIP.
REQ-016 VERIFY: on match, increment match_cnt and go to LOCKED when it reaches LOCK_COUNT; on mismatch, go to SLIP with match_cnt cleared.
REQ-017 SLIP: calib_o SHALL be high for exactly this one cycle; slip_try SHALL increment; next state SHALL be SETTLE with settle_cnt=0.
REQ-018 SETTLE: calib_o low; return to SEARCH after CALIB_SETTLE cycles; q_i SHALL be ignored during SETTLE.
REQ-019 When slip_try reaches MAX_SLIPS, error_o SHALL set, slip_try SHALL wrap to 0, and searching SHALL continue.
REQ-020 error_o SHALL stay set until realign_i or reset, and SHALL remain set through a subsequent lock.
REQ-021 LOCKED: locked_o=1; data_o<=q_i and valid_o<=1 every cycle, giving 1-cycle latency; slip_try SHALL clear on entry.
REQ-022 LOCKED SHALL be left only on realign_i or reset; data content is not monitored.
REQ-023 realign_i SHALL have priority in every state: the next state is SEARCH, and the same edge clears match_cnt, slip_try, error_o, locked_o and valid_o.
REQ-024 If realign_i arrives in SLIP, the calib_o pulse already in progress that cycle SHALL complete; no further pulse is issued.
REQ-025 calib_o, valid_o, locked_o and error_o SHALL be registered, glitch-free outputs.
REQ-026 Outside LOCKED, valid_o SHALL be 0; data_o SHALL hold its last value.

Reset
REQ-027 With nrst_i low at a clk_i edge, the state SHALL become SEARCH and calib_o, valid_o, locked_o, error_o and data_o SHALL all become 0, along with all counters.
REQ-028 Reset applied mid-SLIP or mid-SETTLE SHALL abort the sequence; calib_o SHALL be 0 from the next edge.

Configuration
REQ-029 Macro IDES8_ALIGN_STATS_EN defined: add output slip_cnt_o [7:0], counting total calib pulses since reset or realign_i, saturating at 8'hFF.
REQ-030 Macro undefined: port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Package ides8_align_pkg SHALL hold the FSM state enum, the default pattern constant 8'hB5, and the counter width constants.
REQ-032 A single RTL module; no sub-module is required.

Verification
REQ-033 Bench IDES8 model sends 8'hB5 already aligned -> no calib_o; locked_o=1 and valid_o=1 after 4 cycles; data_o=8'hB5 one cycle after q_i.
REQ-034 Model sends the word rotated by 3 bits and advances one bit per calib_o -> exactly 3 calib pulses, each followed by 3 settle cycles, then lock; slip_cnt_o=3 when enabled.
REQ-035 Model never matches -> error_o=1 after the 8th pulse; pulses continue; model then matches -> lock achieved with error_o still 1.
REQ-036 Match on 2 cycles, then mismatch in VERIFY -> calib_o pulse next cycle; match_cnt restarts from 0.
REQ-037 realign_i while LOCKED, and again during SLIP -> SEARCH next cycle with valid_o, locked_o and error_o at 0; the in-flight pulse stays 1 cycle.
REQ-038 nrst_i low for 1 cycle during SETTLE -> all outputs 0 at the next edge; alignment restarts from SEARCH.
